// File: rtl/mac_tree_accum_pkg.sv
// Shared types for the tree accumulator: FSM state encoding and the result entry
// that travels through the output FIFO.
// Entry fields are sized for the widest supported configuration; the top zero-extends
// into them, so unused upper bits are constant and trimmed by synthesis.
package mac_tree_accum_pkg;

    typedef enum logic {
        IDLE  = 1'b0,   // no partial sum held (count == 0)
        ACCUM = 1'b1    // 0 < count < NUM_CHUNKS
    } state_t;

    localparam int ACC_MAX_W = 64;
    localparam int TAG_MAX_W = 16;

    typedef struct packed {
        logic [ACC_MAX_W-1:0] res;
        logic [TAG_MAX_W-1:0] addr_i;
        logic [TAG_MAX_W-1:0] addr_k;
    } res_entry_t;

endpackage

// File: rtl/mac_tree_accum_fifo.sv
// Purpose: synchronous FIFO for accumulated results, full/empty flags from an occupancy count.
// Latency: a pushed entry is visible on pop_dat the cycle after the push.
// Backpressure: push on full is dropped unless a pop happens in the same cycle.
// Ports: clk/reset, push/push_dat (write side), pop/pop_dat (read side), full, empty.
module mac_tree_accum_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (occ == CW'(DEPTH));
    assign empty   = (occ == '0);
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot being written (wr_ptr == rd_ptr).
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int n = 0; n < DEPTH; n++) begin
                mem[n] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (do_push && !do_pop) begin
                occ <= occ + CW'(1);
            end else if (do_pop && !do_push) begin
                occ <= occ - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mac_tree_accum.sv
// Purpose: sums NUM_CHUNKS tagged tree beats into one result and queues it with its tags.
// Latency: res_val rises the cycle after the final beat when the FIFO is empty.
// Backpressure: none toward the tree; results arriving at a full FIFO are dropped (sticky overflow).
// Ports: sum_in/addr_i_in/addr_k_in/val_in beat input, clear abort, res_out/addr_*_out/res_val/res_rdy
//        result stream, overflow and tag_err sticky flags. Define MAC_TREE_ACCUM_SATURATE_EN to clamp
//        additions at 2^ACC_WIDTH-1 instead of wrapping.
module mac_tree_accum
    import mac_tree_accum_pkg::*;
#(
    parameter int SUM_WIDTH       = 32,
    parameter int ACC_WIDTH       = 40,
    parameter int ADDRESS_WIDTH_I = 8,
    parameter int ADDRESS_WIDTH_K = 8,
    parameter int NUM_CHUNKS      = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SUM_WIDTH-1:0]       sum_in,
    input  logic [ADDRESS_WIDTH_I-1:0] addr_i_in,
    input  logic [ADDRESS_WIDTH_K-1:0] addr_k_in,
    input  logic                       val_in,
    input  logic                       clear,
    output logic [ACC_WIDTH-1:0]       res_out,
    output logic [ADDRESS_WIDTH_I-1:0] addr_i_out,
    output logic [ADDRESS_WIDTH_K-1:0] addr_k_out,
    output logic                       res_val,
    input  logic                       res_rdy,
    output logic                       overflow,
    output logic                       tag_err
);

    localparam int CW = $clog2(NUM_CHUNKS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_CHUNKS);

    state_t                     state;
    logic [CW-1:0]              count;
    logic [ACC_WIDTH-1:0]       acc;
    logic [ADDRESS_WIDTH_I-1:0] tag_i;
    logic [ADDRESS_WIDTH_K-1:0] tag_k;

    logic                       tag_miss;
    logic                       first_beat;
    logic [ACC_WIDTH-1:0]       beat_acc;
    logic [CW-1:0]              beat_cnt;
    logic [ADDRESS_WIDTH_I-1:0] beat_i;
    logic [ADDRESS_WIDTH_K-1:0] beat_k;
    logic                       done;
    logic                       pop;
    logic                       drop;
    logic                       fifo_full;
    logic                       fifo_empty;
    res_entry_t                 push_dat;
    res_entry_t                 pop_dat;
    logic                       unused_entry_bits;

    function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [SUM_WIDTH-1:0] b);
`ifdef MAC_TREE_ACCUM_SATURATE_EN
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + (ACC_WIDTH + 1)'(b);
        return s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
`else
        return a + ACC_WIDTH'(b);
`endif
    endfunction

    // A beat restarts the accumulation when nothing is held, on clear, or on a tag change;
    // in all three cases it is loaded as a fresh first beat.
    always_comb begin
        tag_miss   = (state == ACCUM) && ((addr_i_in != tag_i) || (addr_k_in != tag_k));
        first_beat = (state == IDLE) || clear || tag_miss;
        beat_acc   = first_beat ? ACC_WIDTH'(sum_in) : acc_add(acc, sum_in);
        beat_cnt   = first_beat ? CW'(1) : count + CW'(1);
        beat_i     = first_beat ? addr_i_in : tag_i;
        beat_k     = first_beat ? addr_k_in : tag_k;
        done       = val_in && (beat_cnt == LAST_CNT);

        push_dat        = '0;
        push_dat.res    = ACC_MAX_W'(beat_acc);
        push_dat.addr_i = TAG_MAX_W'(beat_i);
        push_dat.addr_k = TAG_MAX_W'(beat_k);
    end

    assign pop  = res_val && res_rdy;
    assign drop = done && fifo_full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            tag_i    <= '0;
            tag_k    <= '0;
            overflow <= 1'b0;
            tag_err  <= 1'b0;
        end else begin
            // A clear in the same cycle makes the beat a legitimate first beat, not a tag error.
            if (val_in && tag_miss && !clear) begin
                tag_err <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (val_in) begin
                if (done) begin
                    state <= IDLE;
                    count <= '0;
                end else begin
                    state <= ACCUM;
                    count <= beat_cnt;
                    acc   <= beat_acc;
                    tag_i <= beat_i;
                    tag_k <= beat_k;
                end
            end else if (clear) begin
                state <= IDLE;
                count <= '0;
            end
        end
    end

    mac_tree_accum_fifo #(
        .WIDTH ($bits(res_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (done),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign res_val    = !fifo_empty;
    assign res_out    = pop_dat.res[ACC_WIDTH-1:0];
    assign addr_i_out = pop_dat.addr_i[ADDRESS_WIDTH_I-1:0];
    assign addr_k_out = pop_dat.addr_k[ADDRESS_WIDTH_K-1:0];
    assign unused_entry_bits = ^pop_dat;

endmodule

// File: tb/tb_mac_tree_accum.sv
module tb_mac_tree_accum;
    localparam int NCH   = 4;
    localparam int DEPTH = 4;
    localparam logic [63:0] ACC_MAX = (64'd1 << 40) - 64'd1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] sum_in = '0;
    logic [7:0]  addr_i_in = '0, addr_k_in = '0;
    logic        val_in = 1'b0, clear = 1'b0, res_rdy = 1'b0;
    logic [39:0] res_out;
    logic [7:0]  addr_i_out, addr_k_out;
    logic        res_val, overflow, tag_err;

    logic [7:0]  sum8 = '0;
    logic        val8 = 1'b0;
    logic [7:0]  res8, ai8, ak8;
    logic        res_val8, ovf8, terr8;

    always #5 clk = ~clk;

    mac_tree_accum dut (
        .clk(clk), .reset(reset), .sum_in(sum_in), .addr_i_in(addr_i_in), .addr_k_in(addr_k_in),
        .val_in(val_in), .clear(clear), .res_out(res_out), .addr_i_out(addr_i_out),
        .addr_k_out(addr_k_out), .res_val(res_val), .res_rdy(res_rdy), .overflow(overflow),
        .tag_err(tag_err)
    );

    mac_tree_accum #(.SUM_WIDTH(8), .ACC_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .sum_in(sum8), .addr_i_in(8'd0), .addr_k_in(8'd0),
        .val_in(val8), .clear(1'b0), .res_out(res8), .addr_i_out(ai8), .addr_k_out(ak8),
        .res_val(res_val8), .res_rdy(1'b1), .overflow(ovf8), .tag_err(terr8)
    );

    // Reference model: current group as a list of beats, output queue as a list of entries.
    typedef struct { logic [39:0] res; logic [7:0] ai; logic [7:0] ak; } ent_t;
    ent_t        mq[$];
    logic [31:0] cur[$];
    logic [7:0]  cur_i, cur_k;
    logic        m_ovf, m_terr;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [39:0] group_total();
        logic [63:0] total = 0;
        foreach (cur[n]) total += 64'(cur[n]);
`ifdef MAC_TREE_ACCUM_SATURATE_EN
        if (total > ACC_MAX) total = ACC_MAX;
`endif
        return total[39:0];
    endfunction

    task automatic model_reset();
        mq.delete();
        cur.delete();
        m_ovf  = 1'b0;
        m_terr = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] s, input logic [7:0] i,
                              input logic [7:0] k, input logic clr, input logic rdy);
        bit   pop      = (mq.size() > 0) && rdy;
        bit   was_full = (mq.size() == DEPTH);
        bit   have_res = 0;
        ent_t e;
        if (pop) void'(mq.pop_front());
        if (v) begin
            if (cur.size() > 0 && !clr && (i != cur_i || k != cur_k)) m_terr = 1'b1;
            if (clr || cur.size() == 0 || i != cur_i || k != cur_k) begin
                cur.delete();
                cur_i = i;
                cur_k = k;
            end
            cur.push_back(s);
            if (cur.size() == NCH) begin
                e.res = group_total(); e.ai = cur_i; e.ak = cur_k;
                have_res = 1;
                cur.delete();
            end
        end else if (clr) begin
            cur.delete();
        end
        if (have_res) begin
            if (!was_full || pop) mq.push_back(e);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic model_check();
        chk("res_val", res_val, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("res_out", res_out, mq[0].res);
            chk("addr_i_out", addr_i_out, mq[0].ai);
            chk("addr_k_out", addr_k_out, mq[0].ak);
        end
        chk("overflow", overflow, m_ovf);
        chk("tag_err", tag_err, m_terr);
    endtask

    // Drive one cycle's inputs, step the model at the edge, check at the next falling edge.
    task automatic cycle(input logic v, input logic [31:0] s, input logic [7:0] i,
                         input logic [7:0] k, input logic clr, input logic rdy);
        val_in = v; sum_in = s; addr_i_in = i; addr_k_in = k; clear = clr; res_rdy = rdy;
        @(posedge clk);
        model_step(v, s, i, k, clr, rdy);
        @(negedge clk);
        model_check();
    endtask

    task automatic do_reset();
        val_in = 1'b0; clear = 1'b0; val8 = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_res_val_immediate", res_val, 0);
        model_reset();
        @(negedge clk);
        chk("rst_res_out", res_out, 0);
        chk("rst_addr_i", addr_i_out, 0);
        chk("rst_addr_k", addr_k_out, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tag_err", tag_err, 0);
        reset = 1'b1;
    endtask

    typedef struct {
        logic v; logic [31:0] s; logic [7:0] i; logic [7:0] k; logic clr; logic rdy;
        logic ev; logic [39:0] er; logic [7:0] ei; logic [7:0] ek;
    } vec_t;
    vec_t tbl[5];

    initial begin
        logic [7:0] exp8;
        model_reset();
        @(negedge clk);
        chk("init_res_val", res_val, 0);
        do_reset();

        // Four beats of one tag produce one result the cycle after the last beat.
        tbl[0] = '{1, 10, 3, 5, 0, 1, 0, 0,   0, 0};
        tbl[1] = '{1, 20, 3, 5, 0, 1, 0, 0,   0, 0};
        tbl[2] = '{1, 30, 3, 5, 0, 1, 0, 0,   0, 0};
        tbl[3] = '{1, 40, 3, 5, 0, 1, 1, 100, 3, 5};
        tbl[4] = '{0, 0,  0, 0, 0, 1, 0, 0,   0, 0};
        foreach (tbl[n]) begin
            cycle(tbl[n].v, tbl[n].s, tbl[n].i, tbl[n].k, tbl[n].clr, tbl[n].rdy);
            chk("tbl_res_val", res_val, tbl[n].ev);
            if (tbl[n].ev) begin
                chk("tbl_res_out", res_out, tbl[n].er);
                chk("tbl_addr_i", addr_i_out, tbl[n].ei);
                chk("tbl_addr_k", addr_k_out, tbl[n].ek);
            end
        end

        // Five results into a 4-deep FIFO with the consumer stalled: the fifth is dropped.
        for (int g = 0; g < 5; g++)
            for (int b = 0; b < NCH; b++)
                cycle(1, 32'(g + 1), 8'(g), 8'(g + 10), 0, 0);
        chk("ovf_set", overflow, 1);
        for (int n = 0; n < 4; n++) begin
            chk("drain_res_val", res_val, 1);
            chk("drain_order", res_out, 40'(4 * (n + 1)));
            cycle(0, 0, 0, 0, 0, 1);
        end
        chk("drain_empty", res_val, 0);

        // Tag change mid-accumulation restarts with the new beat.
        do_reset();
        cycle(1, 5, 1, 0, 0, 1);
        cycle(1, 6, 1, 0, 0, 1);
        cycle(1, 7, 2, 0, 0, 1);
        chk("tag_err_set", tag_err, 1);
        cycle(1, 8, 2, 0, 0, 1);
        cycle(1, 9, 2, 0, 0, 1);
        cycle(1, 10, 2, 0, 0, 1);
        chk("tag_restart_val", res_val, 1);
        chk("tag_restart_res", res_out, 34);
        chk("tag_restart_i", addr_i_out, 2);
        cycle(0, 0, 0, 0, 0, 1);

        // clear with a simultaneous beat: that beat starts the next group.
        cycle(1, 1, 0, 0, 0, 1);
        cycle(1, 2, 0, 0, 0, 1);
        cycle(1, 7, 0, 0, 1, 1);
        chk("clear_keeps_tag_err", tag_err, 1);
        cycle(1, 3, 0, 0, 0, 1);
        cycle(1, 4, 0, 0, 0, 1);
        chk("clear_no_early", res_val, 0);
        cycle(1, 5, 0, 0, 0, 1);
        chk("clear_res", res_out, 19);
        cycle(0, 0, 0, 0, 0, 1);

        // 8-bit accumulator: 200+100 wraps to 44, or clamps to 255 when saturating.
`ifdef MAC_TREE_ACCUM_SATURATE_EN
        exp8 = 8'd255;
`else
        exp8 = 8'd44;
`endif
        val8 = 1; sum8 = 200; cycle(0, 0, 0, 0, 0, 1);
        sum8 = 100;           cycle(0, 0, 0, 0, 0, 1);
        sum8 = 0;             cycle(0, 0, 0, 0, 0, 1);
        chk("w8_no_early", res_val8, 0);
                              cycle(0, 0, 0, 0, 0, 1);
        val8 = 0;
        chk("w8_res_val", res_val8, 1);
        chk("w8_res", res8, 64'(exp8));

        // Reset with queued results and a partial group discards everything.
        do_reset();
        for (int n = 0; n < 10; n++) cycle(1, 1, 0, 0, 0, 0);
        chk("queued_before_reset", res_val, 1);
        do_reset();
        cycle(1, 1, 0, 0, 0, 1);
        cycle(1, 2, 0, 0, 0, 1);
        cycle(1, 3, 0, 0, 0, 1);
        chk("post_rst_no_early", res_val, 0);
        cycle(1, 4, 0, 0, 0, 1);
        chk("post_rst_res_val", res_val, 1);
        chk("post_rst_res", res_out, 10);
        cycle(0, 0, 0, 0, 0, 1);
        chk("post_rst_single", res_val, 0);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom,
                  ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 3)) : 8'd1,
                  ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 3)) : 8'd2,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
        end
        for (int n = 0; n < 8; n++) cycle(0, 0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_tree_accum.md
MAC_TREE_ACCUM -- requirements
Module: mac_tree_accum

Interface
REQ-001 SHALL have parameter SUM_WIDTH, default 32: width of incoming tree sum.
REQ-002 SHALL have parameter ACC_WIDTH, default 40: accumulator and result width, at least SUM_WIDTH.
REQ-003 SHALL have parameter ADDRESS_WIDTH_I, default 8: row address width.
REQ-004 SHALL have parameter ADDRESS_WIDTH_K, default 8: column address width.
REQ-005 SHALL have parameter NUM_CHUNKS, default 4: tree beats summed per result, at least 1.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries, a power of 2.
REQ-007 SHALL have one clock and an asynchronous active-low reset, with ports named as below:
  clk  in  1  clock
  reset  in  1  asynchronous active-low reset
REQ-008 SHALL have the following data and control ports:
  sum_in  in  SUM_WIDTH  tree sum beat
  addr_i_in  in  ADDRESS_WIDTH_I  row tag of the beat
  addr_k_in  in  ADDRESS_WIDTH_K  column tag of the beat
  val_in  in  1  beat valid; no backpressure to the tree
  clear  in  1  sync abort of partial accumulation
  res_out  out  ACC_WIDTH  accumulated result
  addr_i_out  out  ADDRESS_WIDTH_I  result row tag
  addr_k_out  out  ADDRESS_WIDTH_K  result column tag
  res_val  out  1  result valid
  res_rdy  in  1  consumer ready
  overflow  out  1  sticky: a result was dropped on a full FIFO
  tag_err  out  1  sticky: a beat arrived whose tag did not match

Function
REQ-009 SHALL use FSM states IDLE (count=0) and ACCUM (0<count<NUM_CHUNKS).
REQ-010 In IDLE, a val_in beat SHALL load acc=zero-extended sum_in, latch the tags, set count=1, and move to ACCUM (or finish, if NUM_CHUNKS=1).
REQ-011 In ACCUM, a val_in beat SHALL set acc+=sum_in modulo 2^ACC_WIDTH and increment count.
REQ-012 The beat that makes count equal NUM_CHUNKS SHALL push {acc+sum_in, latched tags} to the FIFO and return the FSM to IDLE in the same cycle.
REQ-013 Latency: with an empty FIFO, res_val SHALL rise the cycle after the final beat.
REQ-014 A result SHALL transfer when res_val&&res_rdy; res_out and tags SHALL hold stable while res_val&&!res_rdy.
REQ-015 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-016 Otherwise the result SHALL be discarded and overflow set; the FSM still returns to IDLE.
REQ-017 In ACCUM, a beat whose addr_i_in or addr_k_in differs from the latched tag SHALL set tag_err, discard the partial sum, and restart as a first beat per REQ-010.
REQ-018 clear SHALL discard the partial sum and return to IDLE; a val_in in the same cycle SHALL be treated as a first beat.
REQ-019 clear SHALL NOT affect FIFO contents, overflow, or tag_err.
REQ-020 Cycles with val_in=0 SHALL leave acc, count, and the FSM unchanged.
REQ-021 When empty, the FIFO SHALL drive res_val=0; res_out and tags are then don't-care.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-023 Reset asserted SHALL clear FSM to IDLE, count, acc, FIFO pointers and occupancy, res_val, overflow, and tag_err to 0, and drive res_out and tags to 0.
REQ-024 Reset asserted mid-accumulation SHALL discard all partial and queued results; the first beat after release SHALL be a first beat.

Configuration
REQ-025 With MAC_TREE_ACCUM_SATURATE_EN defined, additions SHALL clamp to 2^ACC_WIDTH-1 and never wrap; without it, additions SHALL wrap modulo 2^ACC_WIDTH.

Structure
REQ-026 Package mac_tree_accum_pkg SHALL hold the FSM state enum and a result-entry typedef (result plus two tags).
REQ-027 The output FIFO SHALL be sub-module mac_tree_accum_fifo (synchronous, registered outputs, full/empty flags).

Verification
REQ-028 NUM_CHUNKS=4, beats 10,20,30,40 tagged i=3,k=5, res_rdy=1 -> one result 100, i=3, k=5; res_val high the cycle after the 4th beat.
REQ-029 res_rdy=0, 5 complete results pushed with FIFO_DEPTH=4 -> 4 queued, overflow=1; then res_rdy=1 -> the first 4 results drain in order.
REQ-030 Beats tagged i=1,1 then i=2 -> tag_err=1; the i=2 beat starts a new accumulation whose result carries only i=2 beats.
REQ-031 clear after 2 beats, with val_in=7 in the same cycle -> the next result equals 7 plus the following 3 beats.
REQ-032 ACC_WIDTH=SUM_WIDTH=8, beats 200,100,0,0 -> result 44 without the macro; 255 with MAC_TREE_ACCUM_SATURATE_EN.
REQ-033 reset asserted after 2 beats with 2 results queued -> res_val=0 immediately; the next 4 beats yield exactly one result.
